passcode_controller: RTL and testbench

//  Sequences keypad-style passcode entry for the alarm: samples a 4-bit digit on each Enter press,

---
 rtl/passcode_controller_pkg.sv | 37 +++
 rtl/passcode_controller_btn_sync_edge.sv | 29 ++
 rtl/passcode_controller.sv | 198 +++++++++++++++++++
 tb/tb_passcode_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/passcode_controller_pkg.sv
// Shared types and constants for the alarm passcode controller: system and
// controller state enums, clock rate, digit width and small decode helpers.
package passcode_controller_pkg;

   localparam int unsigned CLK_HZ  = 50_000_000;
   localparam int          DIGIT_W = 4;

   typedef enum logic [1:0] {
      SYS_IDLE,
      SYS_SET,
      SYS_TRIGGER,
      SYS_ALERT
   } fsm_state_t;

   typedef enum logic [2:0] {
      PC_IDLE,
      PC_ENTRY,
      PC_CHECK,
      PC_NEWCODE,
      PC_LOCKOUT
   } pc_state_t;

   typedef enum logic {
      MODE_VERIFY,
      MODE_CHANGE
   } pc_mode_t;

   // Verify sessions are only meaningful while the alarm is armed or counting down.
   function automatic logic is_armed(input fsm_state_t s);
      return (s == SYS_SET) || (s == SYS_TRIGGER);
   endfunction

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/passcode_controller_btn_sync_edge.sv
// Two-flop synchroniser for a raw active-low button, followed by a falling-edge
// detector producing a single-cycle press pulse.
module passcode_controller_btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_press_p
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: reset to the released (high) level so leaving reset never looks like a press.
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_press_p = r_prev & ~r_sync2;

endmodule

// File: rtl/passcode_controller.sv
// Keypad passcode sequencer: collects BCD digits on Enter presses, verifies or
// changes the stored code, and enforces lockout after repeated failures.
module passcode_controller
   import passcode_controller_pkg::*;
#(
   parameter int                          DIGITS         = 4,
   parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
   parameter int unsigned                 MAX_TRIES      = 3,
   parameter int unsigned                 LOCKOUT_CYCLES = 5 * CLK_HZ,
   parameter int unsigned                 TIMEOUT_CYCLES = 10 * CLK_HZ
) (
   input  logic               clk,
   input  logic               rst,
   input  fsm_state_t         system_state,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               btn_enter,
   input  logic               btn_change,
   output logic               passcode_correct,
   output logic               passcode_wrong,
   output logic               code_updated,
   output logic               locked_out,
   output logic [2:0]         digit_count
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

   pc_state_t         r_state;
   pc_mode_t          r_mode;
   logic [CODE_W-1:0] r_code;
   logic [CODE_W-1:0] r_buf;
   logic [2:0]        r_count;
   logic [TRY_W-1:0]  r_tries;
   logic [GAP_W-1:0]  r_gap;
   logic [LOCK_W-1:0] r_lock;
   logic              r_correct;
   logic              r_wrong;
   logic              r_updated;
   logic              r_locked;

   logic              w_enter_p;
   logic              w_change_p;
   logic              w_armed;
   logic              w_sys_idle;
   logic              w_digit_ok;
   logic              w_accept;
   logic              w_last;
   logic              w_abort;
   logic              w_gap_done;
   logic              w_lock_done;
   logic [CODE_W-1:0] w_shifted;
   logic [TRY_W-1:0]  w_tries_inc;

   passcode_controller_btn_sync_edge u_enter_sync (
      .clk       (clk),
      .rst       (rst),
      .i_btn_n   (btn_enter),
      .o_press_p (w_enter_p)
   );

   passcode_controller_btn_sync_edge u_change_sync (
      .clk       (clk),
      .rst       (rst),
      .i_btn_n   (btn_change),
      .o_press_p (w_change_p)
   );

   assign w_armed     = is_armed(system_state);
   assign w_sys_idle  = (system_state == SYS_IDLE);
   assign w_digit_ok  = is_bcd(digit_in);
   assign w_accept    = w_enter_p & w_digit_ok;
   assign w_last      = (r_count == 3'(DIGITS - 1));
   assign w_abort     = (r_mode == MODE_VERIFY) ? !w_armed : !w_sys_idle;
   assign w_shifted   = {r_buf[CODE_W-DIGIT_W-1:0], digit_in};
   assign w_gap_done  = (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
   assign w_lock_done = (r_lock == LOCK_W'(LOCKOUT_CYCLES - 1));
   assign w_tries_inc = (r_tries == TRY_W'(MAX_TRIES)) ? r_tries : r_tries + TRY_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= PC_IDLE;
         r_mode    <= MODE_VERIFY;
         r_code    <= DEFAULT_CODE;
         r_buf     <= '0;
         r_count   <= '0;
         r_tries   <= '0;
         r_gap     <= '0;
         r_lock    <= '0;
         r_correct <= 1'b0;
         r_wrong   <= 1'b0;
         r_updated <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each cycle; later assignments in this block win.
         r_correct <= 1'b0;
         r_wrong   <= 1'b0;
         r_updated <= 1'b0;

         unique case (r_state)
            PC_IDLE: begin
               r_buf   <= '0;
               r_count <= '0;
               r_gap   <= '0;
               if (w_change_p && w_sys_idle) begin
                  r_state <= PC_ENTRY;
                  r_mode  <= MODE_CHANGE;
               end else if (w_enter_p && w_armed) begin
                  r_state <= PC_ENTRY;
                  r_mode  <= MODE_VERIFY;
                  if (w_digit_ok) begin
                     r_buf   <= w_shifted;
                     r_count <= 3'd1;
                  end
               end
            end

            PC_ENTRY, PC_NEWCODE: begin
               if (w_abort) begin
                  r_state <= PC_IDLE;
                  r_buf   <= '0;
                  r_count <= '0;
               end else if (w_accept) begin
                  r_buf <= w_shifted;
                  r_gap <= '0;
                  if (!w_last) begin
                     r_count <= r_count + 3'd1;
                  end else if (r_state == PC_ENTRY) begin
                     r_count <= r_count + 3'd1;
                     r_state <= PC_CHECK;
                  end else begin
                     // New code is committed only once every digit has arrived.
                     r_code    <= w_shifted;
                     r_updated <= 1'b1;
                     r_buf     <= '0;
                     r_count   <= '0;
                     r_state   <= PC_IDLE;
                  end
               end else if (w_gap_done) begin
                  r_state <= PC_IDLE;
                  r_buf   <= '0;
                  r_count <= '0;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end

            PC_CHECK: begin
               r_buf   <= '0;
               r_count <= '0;
               r_gap   <= '0;
               if (w_abort) begin
                  r_state <= PC_IDLE;
               end else if (r_buf == r_code) begin
                  r_tries <= '0;
                  if (r_mode == MODE_CHANGE) begin
                     r_state <= PC_NEWCODE;
                  end else begin
                     r_correct <= 1'b1;
                     r_state   <= PC_IDLE;
                  end
               end else begin
                  r_wrong <= 1'b1;
                  r_tries <= w_tries_inc;
                  if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                     r_state  <= PC_LOCKOUT;
                     r_locked <= 1'b1;
                     r_lock   <= '0;
                  end else begin
                     r_state <= PC_IDLE;
                  end
               end
            end

            PC_LOCKOUT: begin
               if (w_lock_done) begin
                  r_state  <= PC_IDLE;
                  r_locked <= 1'b0;
                  r_tries  <= '0;
                  r_lock   <= '0;
               end else begin
                  r_lock <= r_lock + LOCK_W'(1);
               end
            end

            default: r_state <= PC_IDLE;
         endcase
      end
   end

   assign passcode_correct = r_correct;
   assign passcode_wrong   = r_wrong;
   assign code_updated     = r_updated;
   assign locked_out       = r_locked;
   assign digit_count      = r_count;

endmodule

// File: tb/tb_passcode_controller.sv
// Self-checking bench for passcode_controller: directed scenarios plus randomized
// verify/change sessions scored against a code/tries reference model.
module tb_passcode_controller;
   import passcode_controller_pkg::*;

   localparam int unsigned LOCK_N = 20;
   localparam int unsigned TMO_N  = 50;
   localparam int          MAX_T  = 3;

   logic       clk = 1'b0;
   logic       rst;
   fsm_state_t system_state;
   logic [3:0] digit_in;
   logic       btn_enter;
   logic       btn_change;
   logic       passcode_correct;
   logic       passcode_wrong;
   logic       code_updated;
   logic       locked_out;
   logic [2:0] digit_count;

   passcode_controller #(
      .DIGITS         (4),
      .DEFAULT_CODE   (16'h1234),
      .MAX_TRIES      (MAX_T),
      .LOCKOUT_CYCLES (LOCK_N),
      .TIMEOUT_CYCLES (TMO_N)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .system_state     (system_state),
      .digit_in         (digit_in),
      .btn_enter        (btn_enter),
      .btn_change       (btn_change),
      .passcode_correct (passcode_correct),
      .passcode_wrong   (passcode_wrong),
      .code_updated     (code_updated),
      .locked_out       (locked_out),
      .digit_count      (digit_count)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Cycle-accurate tallies of every output pulse / lockout cycle seen.
   int cnt_correct = 0;
   int cnt_wrong   = 0;
   int cnt_updated = 0;
   int cnt_locked  = 0;

   always @(negedge clk) begin
      if (passcode_correct) cnt_correct++;
      if (passcode_wrong)   cnt_wrong++;
      if (code_updated)     cnt_updated++;
      if (locked_out)       cnt_locked++;
   end

   // Reference model: stored code, consecutive failures, expected pulse totals.
   logic [15:0] m_code;
   int          m_tries;
   int          e_correct = 0;
   int          e_wrong   = 0;
   int          e_updated = 0;

   logic [2:0] s_cnt3;
   logic [2:0] s_cnt4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Enter press: the controller acts on the third rising edge after the press.
   task automatic press(input logic [3:0] d);
      digit_in  = d;
      btn_enter = 1'b0;
      cycles(3);
      s_cnt3 = digit_count;
      cycles(1);
      s_cnt4 = digit_count;
      btn_enter = 1'b1;
      cycles(4);
   endtask

   task automatic press_change();
      btn_change = 1'b0;
      cycles(4);
      btn_change = 1'b1;
      cycles(4);
   endtask

   function automatic logic [15:0] rand_code();
      logic [15:0] c;
      for (int i = 0; i < 4; i++) c[15-4*i -: 4] = 4'($urandom_range(9, 0));
      return c;
   endfunction

   task automatic check_totals(input string tag);
      check({tag, "_correct"}, cnt_correct, e_correct);
      check({tag, "_wrong"},   cnt_wrong,   e_wrong);
      check({tag, "_updated"}, cnt_updated, e_updated);
   endtask

   // One verify attempt, optionally with an out-of-range digit slipped in mid-code.
   task automatic attempt(input logic [15:0] code, input bit add_invalid);
      int bad_pos;
      int lock_base;
      bit lock_exp;
      bad_pos   = add_invalid ? int'($urandom_range(3, 1)) : -1;
      lock_base = cnt_locked;
      for (int i = 0; i < 4; i++) begin
         if (i == bad_pos) begin
            press(4'($urandom_range(15, 10)));
            check("invalid_ignored", 32'(digit_count), i);
         end
         press(code[15-4*i -: 4]);
         if (i < 3) check("count_step", 32'(s_cnt4), i + 1);
      end
      check("count_full", 32'(s_cnt3), 4);
      check("count_cleared", 32'(digit_count), 0);
      lock_exp = 1'b0;
      if (code == m_code) begin
         e_correct++;
         m_tries = 0;
      end else begin
         e_wrong++;
         m_tries++;
         if (m_tries >= MAX_T) lock_exp = 1'b1;
      end
      check_totals("attempt");
      check("locked_state", 32'(locked_out), 32'(lock_exp));
      if (lock_exp) begin
         press(code[15:12]);
         check("lockout_press_ignored", 32'(digit_count), 0);
         cycles(int'(LOCK_N) + 5);
         check("lockout_released", 32'(locked_out), 0);
         check("lockout_length", cnt_locked - lock_base, LOCK_N);
         m_tries = 0;
      end
   endtask

   // Change session: stored code first, then the replacement.
   task automatic change_code(input logic [15:0] new_code);
      logic [15:0] old_code;
      old_code     = m_code;
      system_state = SYS_IDLE;
      press_change();
      check("chg_open_count", 32'(digit_count), 0);
      for (int i = 0; i < 4; i++) press(old_code[15-4*i -: 4]);
      check("chg_old_full", 32'(s_cnt3), 4);
      check("chg_newcode_count", 32'(digit_count), 0);
      for (int i = 0; i < 4; i++) begin
         press(new_code[15-4*i -: 4]);
         if (i < 3) check("chg_new_step", 32'(s_cnt4), i + 1);
      end
      e_updated++;
      m_code  = new_code;
      m_tries = 0;
      check_totals("change");
      check("chg_count_end", 32'(digit_count), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      system_state = SYS_IDLE;
      digit_in     = 4'd0;
      btn_enter    = 1'b1;
      btn_change   = 1'b1;
      m_code       = 16'h1234;
      m_tries      = 0;
      cycles(3);
      check("rst_correct", 32'(passcode_correct), 0);
      check("rst_wrong",   32'(passcode_wrong),   0);
      check("rst_updated", 32'(code_updated),     0);
      check("rst_locked",  32'(locked_out),       0);
      check("rst_count",   32'(digit_count),      0);
      rst = 1'b1;
      cycles(3);

      // Default code accepted while armed.
      system_state = SYS_SET;
      attempt(16'h1234, 1'b0);
      check("first_correct_pulse", cnt_correct, 1);

      // Three consecutive failures lock the keypad out, then the code works again.
      for (int k = 0; k < 3; k++) attempt(16'h1235, 1'b0);
      check("three_wrong_pulses", cnt_wrong, 3);
      attempt(16'h1234, 1'b0);

      // Change code in system IDLE, then verify new and old codes.
      change_code(16'h9876);
      system_state = SYS_SET;
      attempt(16'h9876, 1'b0);
      attempt(16'h1234, 1'b0);

      // Timeout mid-code: buffer dropped, no pulse, failure count untouched.
      press(4'd1);
      press(4'd2);
      check("tmo_partial_count", 32'(digit_count), 2);
      cycles(60);
      check("tmo_count_cleared", 32'(digit_count), 0);
      check_totals("tmo");
      attempt(16'h1111, 1'b0);
      attempt(m_code, 1'b0);

      // Out-of-range digit ignored, then session aborted by leaving the armed state.
      press(4'd1);
      press(4'hA);
      check("bad_digit_count", 32'(digit_count), 1);
      press(4'd2);
      check("abort_pre_count", 32'(digit_count), 2);
      system_state = SYS_IDLE;
      cycles(2);
      check("abort_count", 32'(digit_count), 0);
      check_totals("abort");
      system_state = SYS_SET;
      attempt(m_code, 1'b0);

      // ALERT opens no session of either kind.
      system_state = SYS_ALERT;
      press(4'd5);
      check("alert_enter_count", 32'(digit_count), 0);
      press_change();
      press(4'd5);
      check("alert_change_count", 32'(digit_count), 0);
      check_totals("alert");

      // Randomized sessions against the model.
      for (int k = 0; k < 18; k++) begin
         if (k % 6 == 5) begin
            change_code(rand_code());
         end else begin
            system_state = ($urandom_range(1, 0) == 0) ? SYS_SET : SYS_TRIGGER;
            attempt(($urandom_range(1, 0) == 0) ? m_code : rand_code(), 1'($urandom_range(1, 0)));
         end
      end

      // Reset in the middle of entering a new code restores the default code.
      change_code(16'h9876);
      system_state = SYS_IDLE;
      press_change();
      for (int i = 0; i < 4; i++) press(m_code[15-4*i -: 4]);
      press(4'd5);
      press(4'd5);
      check("newcode_partial_count", 32'(digit_count), 2);
      rst = 1'b0;
      cycles(2);
      check("midrst_correct", 32'(passcode_correct), 0);
      check("midrst_wrong",   32'(passcode_wrong),   0);
      check("midrst_updated", 32'(code_updated),     0);
      check("midrst_locked",  32'(locked_out),       0);
      check("midrst_count",   32'(digit_count),      0);
      rst     = 1'b1;
      m_code  = 16'h1234;
      m_tries = 0;
      cycles(3);
      system_state = SYS_SET;
      attempt(16'h1234, 1'b0);
      attempt(16'h9876, 1'b0);
      check_totals("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
